// File: rtl/mul_div_unit.sv
// Iterative signed MULT/DIV: WIDTH cycles in CALC, then a single DONE cycle with HI/LO valid.
// No backpressure: start_i is taken only in IDLE/DONE; busy_o stalls the pipeline during CALC.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [3:0] OP_MULT = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 op_div, neg_res, neg_rem;
  logic [WIDTH:0]       b_mag;
  // Shared accumulator: mult {carry+upper, multiplier}; div {remainder, dividend/quotient}.
  logic [2*WIDTH:0]     acc, acc_step;

  logic                 is_mult, is_div, accept, div_zero, last_iter;
  logic [WIDTH:0]       abs1, abs2;
  logic [WIDTH:0]       mul_sum, shl_upper;
  logic [WIDTH+1:0]     trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign is_mult   = (ALUCtrl_i == OP_MULT);
  assign is_div    = (ALUCtrl_i == OP_DIV);
  assign accept    = start_i && (is_mult || is_div) && (state != CALC);
  assign div_zero  = is_div && (src2_i == '0);
  assign last_iter = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));

  // Magnitudes in WIDTH+1 bits so the most negative operand stays exact.
  assign abs1 = src1_i[WIDTH-1] ? -{src1_i[WIDTH-1], src1_i} : {src1_i[WIDTH-1], src1_i};
  assign abs2 = src2_i[WIDTH-1] ? -{src2_i[WIDTH-1], src2_i} : {src2_i[WIDTH-1], src2_i};

  always_comb begin
    mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? b_mag : '0);
    shl_upper = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial     = {1'b0, shl_upper} - {1'b0, b_mag};
    if (!op_div)
      acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
    else if (!trial[WIDTH+1])
      acc_step = {trial[WIDTH:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {shl_upper, acc[WIDTH-2:0], 1'b0};
    prod_fix = neg_res ? -acc_step[2*WIDTH-1:0] : acc_step[2*WIDTH-1:0];
    quo_fix  = neg_res ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = div_zero ? DONE : CALC;
        else        state_nxt = IDLE;
      end
      CALC:    if (last_iter) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt     <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_mag   <= '0;
      acc     <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else if (accept) begin
      cnt     <= '0;
      op_div  <= is_div;
      neg_res <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
      neg_rem <= src1_i[WIDTH-1];
      b_mag   <= abs2;
      acc     <= {{WIDTH{1'b0}}, abs1};
      if (div_zero) begin
        lo_o <= '1;
        hi_o <= src1_i;
      end
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_step;
      if (last_iter) begin
        if (op_div) begin
          lo_o <= quo_fix;
          hi_o <= rem_fix;
        end else begin
          {hi_o, lo_o} <= prod_fix;
        end
      end
    end
  end

  assign busy_o = (state == CALC);
  assign done_o = (state == DONE);

endmodule
